// File: rtl/stream_expr_evaluator.sv
// stream_expr_evaluator
//   Streaming infix-expression evaluator. Accepts one token per handshake and
//   evaluates it in place with a shunting-yard scheme on a value stack and an
//   operator stack. Produces one WIDTH-bit result plus a 4-bit error code per
//   expression. Only one expression is in flight at a time.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   tok_valid/ready   token handshake; tok_is_op selects operator vs operand
//   tok_data          unsigned operand or ASCII operator code ( ) * + - /
//   tok_last          final token of the expression
//   res_valid/ready   result handshake; result/err are held until taken
//   result            expression value, 0 whenever err != 0
//   err               [0] overflow [1] underflow [2] div by zero [3] paren/opcode
//   busy              expression in progress
module stream_expr_evaluator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 11
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_is_op,
  input  logic [WIDTH-1:0] tok_data,
  input  logic             tok_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       err,
  output logic             busy
);

  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_REDUCE, S_FLUSH, S_DRAIN, S_DONE
  } state_e;

  // Internal operator encoding; C_BAD marks an undefined opcode.
  typedef enum logic [2:0] {
    C_BAD, C_LP, C_RP, C_MUL, C_ADD, C_SUB, C_DIV
  } op_e;

  // Stack/pending-register action selected for this cycle.
  typedef enum logic [2:0] {
    A_NONE, A_PUSH_VAL, A_PUSH_OP, A_POP_OP, A_REDUCE, A_LATCH, A_CLEAR
  } act_e;

  state_e           state;
  state_e           nxt_state;
  act_e             act;
  op_e              push_op;
  logic [3:0]       new_err;

  logic [WIDTH-1:0] val_stk [DEPTH];
  op_e              op_stk  [DEPTH];
  logic [PW-1:0]    vsp;
  logic [PW-1:0]    osp;

  op_e              pend_op;
  logic             pend_last;

  logic             xfer;
  op_e              tok_code;
  op_e              o_top;
  logic [WIDTH-1:0] v_top;
  logic [WIDTH-1:0] v_sec;
  logic [WIDTH-1:0] alu;
  logic [3:0]       red_err;

  function automatic op_e decode(input logic [WIDTH-1:0] d);
    op_e c;
    c = C_BAD;
    if (d == WIDTH'(40)) c = C_LP;
    if (d == WIDTH'(41)) c = C_RP;
    if (d == WIDTH'(42)) c = C_MUL;
    if (d == WIDTH'(43)) c = C_ADD;
    if (d == WIDTH'(45)) c = C_SUB;
    if (d == WIDTH'(47)) c = C_DIV;
    return c;
  endfunction

  // '(' has precedence 0 so a binary operator never reduces past it.
  function automatic logic [1:0] prec(input op_e c);
    logic [1:0] p;
    case (c)
      C_MUL, C_DIV: p = 2'd2;
      C_ADD, C_SUB: p = 2'd1;
      default:      p = 2'd0;
    endcase
    return p;
  endfunction

  assign xfer     = tok_valid & tok_ready;
  assign tok_code = decode(tok_data);

  // Stack tops; guarded so an empty stack never indexes out of range.
  assign o_top = (osp != '0)        ? op_stk[AW'(osp - PW'(1))]  : C_BAD;
  assign v_top = (vsp != '0)        ? val_stk[AW'(vsp - PW'(1))] : '0;
  assign v_sec = (vsp >= PW'(2))    ? val_stk[AW'(vsp - PW'(2))] : '0;

  // Reduction datapath: a op b with a = second entry, b = top entry.
  always_comb begin
    alu     = '0;
    red_err = '0;
    if (vsp < PW'(2)) red_err[1] = 1'b1;
    case (o_top)
      C_ADD: alu = v_sec + v_top;
      C_SUB: alu = v_sec - v_top;
      C_MUL: alu = v_sec * v_top;
      C_DIV: begin
        if (v_top == '0) begin
          if (vsp >= PW'(2)) red_err[2] = 1'b1;
        end else begin
          alu = v_sec / v_top;
        end
      end
      default: alu = '0;
    endcase
  end

  // Next-state / action decode.
  always_comb begin
    nxt_state = state;
    act       = A_NONE;
    new_err   = '0;
    push_op   = tok_code;
    case (state)
      S_IDLE: nxt_state = S_ACCEPT;

      S_ACCEPT: begin
        if (xfer) begin
          if (!tok_is_op) begin
            if (vsp == PW'(DEPTH)) new_err[0] = 1'b1;
            else                   act = A_PUSH_VAL;
          end else begin
            case (tok_code)
              C_LP: begin
                if (osp == PW'(DEPTH)) new_err[0] = 1'b1;
                else                   act = A_PUSH_OP;
              end
              C_RP: begin
                if (osp == '0)          new_err[3] = 1'b1;
                else if (o_top == C_LP) act = A_POP_OP;
                else                    act = A_LATCH;
              end
              C_MUL, C_ADD, C_SUB, C_DIV: begin
                if (osp != '0 && prec(o_top) >= prec(tok_code)) act = A_LATCH;
                else if (osp == PW'(DEPTH))                      new_err[0] = 1'b1;
                else                                             act = A_PUSH_OP;
              end
              default: new_err[3] = 1'b1;
            endcase
          end
          if (new_err != '0)      nxt_state = tok_last ? S_DONE : S_DRAIN;
          else if (act == A_LATCH) nxt_state = S_REDUCE;
          else if (tok_last)       nxt_state = S_FLUSH;
        end
      end

      // Reduce until the pending operator can be placed, then resume.
      S_REDUCE: begin
        push_op = pend_op;
        if (pend_op == C_RP) begin
          if (osp == '0)          new_err[3] = 1'b1;
          else if (o_top == C_LP) act = A_POP_OP;
          else                    act = A_REDUCE;
        end else if (osp == '0 || prec(o_top) < prec(pend_op)) begin
          if (osp == PW'(DEPTH)) new_err[0] = 1'b1;
          else                   act = A_PUSH_OP;
        end else begin
          act = A_REDUCE;
        end
        if (act == A_REDUCE) new_err = red_err;
        if (new_err != '0)        nxt_state = pend_last ? S_DONE : S_DRAIN;
        else if (act != A_REDUCE) nxt_state = pend_last ? S_FLUSH : S_ACCEPT;
      end

      S_FLUSH: begin
        if (osp == '0) begin
          if (vsp != PW'(1)) new_err[1] = 1'b1;
          nxt_state = S_DONE;
        end else if (o_top == C_LP) begin
          new_err[3] = 1'b1;
          nxt_state  = S_DONE;
        end else begin
          act     = A_REDUCE;
          new_err = red_err;
          if (red_err != '0) nxt_state = S_DONE;
        end
      end

      S_DRAIN: begin
        if (xfer && tok_last) nxt_state = S_DONE;
      end

      S_DONE: begin
        if (res_valid && res_ready) begin
          act       = A_CLEAR;
          nxt_state = S_ACCEPT;
        end
      end

      default: nxt_state = S_IDLE;
    endcase
  end

  // FSM state, stack pointers, pending operator and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      vsp       <= '0;
      osp       <= '0;
      pend_op   <= C_BAD;
      pend_last <= 1'b0;
      tok_ready <= 1'b0;
      res_valid <= 1'b0;
      result    <= '0;
      err       <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= nxt_state;
      tok_ready <= (nxt_state == S_ACCEPT) || (nxt_state == S_DRAIN);
      busy      <= !((nxt_state == S_IDLE) || (nxt_state == S_DONE));
      case (act)
        A_PUSH_VAL: vsp <= vsp + PW'(1);
        A_PUSH_OP:  osp <= osp + PW'(1);
        A_POP_OP:   osp <= osp - PW'(1);
        A_REDUCE: begin
          osp <= osp - PW'(1);
          if (!red_err[1]) vsp <= vsp - PW'(1);
        end
        A_LATCH: begin
          pend_op   <= tok_code;
          pend_last <= tok_last;
        end
        A_CLEAR: begin
          vsp <= '0;
          osp <= '0;
        end
        default: ;
      endcase
      if (act == A_CLEAR) begin
        err       <= '0;
        res_valid <= 1'b0;
        result    <= '0;
      end else begin
        err <= err | new_err;
        // Capture the result once, on entry to DONE.
        if (nxt_state == S_DONE && state != S_DONE) begin
          res_valid <= 1'b1;
          result    <= (((err | new_err) == 4'd0) && (vsp == PW'(1))) ? val_stk[0] : '0;
        end
      end
    end
  end

  // Stack storage; contents beyond the pointers are don't-care, so no reset.
  always_ff @(posedge CLK) begin
    if (act == A_PUSH_VAL)               val_stk[AW'(vsp)]            <= tok_data;
    if (act == A_REDUCE && !red_err[1])  val_stk[AW'(vsp - PW'(2))]   <= alu;
    if (act == A_PUSH_OP)                op_stk[AW'(osp)]             <= push_op;
  end

endmodule

// File: tb/tb_stream_expr_evaluator.sv
// Bench for stream_expr_evaluator: two instances (DEPTH 11 and DEPTH 4)
// sharing stimulus through a select; a precedence-pass model checks
// random expressions.
module tb_stream_expr_evaluator;

  localparam int unsigned W = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST;
  logic         tok_valid;
  logic         tok_is_op;
  logic [W-1:0] tok_data;
  logic         tok_last;
  logic         res_ready;
  logic         sel;

  logic         rdy0, rdy1, rv0, rv1, busy0, busy1;
  logic [W-1:0] res0, res1;
  logic [3:0]   err0, err1;

  logic         obs_rdy, obs_rv, obs_busy;
  logic [W-1:0] obs_res;
  logic [3:0]   obs_err;

  assign obs_rdy  = sel ? rdy1  : rdy0;
  assign obs_rv   = sel ? rv1   : rv0;
  assign obs_busy = sel ? busy1 : busy0;
  assign obs_res  = sel ? res1  : res0;
  assign obs_err  = sel ? err1  : err0;

  stream_expr_evaluator #(.WIDTH(W), .DEPTH(11)) dut0 (
    .CLK(CLK), .RST(RST),
    .tok_valid(tok_valid & ~sel), .tok_ready(rdy0),
    .tok_is_op(tok_is_op), .tok_data(tok_data), .tok_last(tok_last),
    .res_valid(rv0), .res_ready(res_ready & ~sel),
    .result(res0), .err(err0), .busy(busy0)
  );

  stream_expr_evaluator #(.WIDTH(W), .DEPTH(4)) dut1 (
    .CLK(CLK), .RST(RST),
    .tok_valid(tok_valid & sel), .tok_ready(rdy1),
    .tok_is_op(tok_is_op), .tok_data(tok_data), .tok_last(tok_last),
    .res_valid(rv1), .res_ready(res_ready & sel),
    .result(res1), .err(err1), .busy(busy1)
  );

  int tests = 0;
  int fails = 0;
  bit model_dz;
  bit gaps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one token and hold it until the selected DUT takes it.
  task automatic send_tok(input logic is_op, input logic [W-1:0] d, input logic last);
    int n;
    bit hit;
    if (gaps) repeat ($urandom_range(0, 2)) @(posedge CLK);
    #1;
    tok_valid = 1'b1; tok_is_op = is_op; tok_data = d; tok_last = last;
    n = 0; hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge CLK);
      hit = obs_rdy;
      @(posedge CLK);
      n++;
    end
    #1;
    tok_valid = 1'b0; tok_last = 1'b0;
    if (!hit) check("tok_accept_timeout", 32'(hit), 32'd1);
  endtask

  // Tokenise an ASCII expression (decimal operands, any other non-space
  // character is an operator code) and stream it with tok_last on the end.
  task automatic send_expr(input string s);
    bit          is_op_q[$];
    logic [W-1:0] d_q[$];
    int          val;
    bit          innum;
    byte         c;
    val = 0; innum = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= 8'd48 && c <= 8'd57) begin
        val = val * 10 + int'(c - 8'd48);
        innum = 1'b1;
      end else begin
        if (innum) begin is_op_q.push_back(1'b0); d_q.push_back(W'(val)); end
        innum = 1'b0; val = 0;
        if (c != 8'd32) begin is_op_q.push_back(1'b1); d_q.push_back(W'(c)); end
      end
    end
    if (innum) begin is_op_q.push_back(1'b0); d_q.push_back(W'(val)); end
    for (int i = 0; i < is_op_q.size(); i++)
      send_tok(is_op_q[i], d_q[i], i == is_op_q.size() - 1);
  endtask

  // Wait for the result, check it, optionally stall res_ready while offering
  // a token, then complete the handshake.
  task automatic get_result(input string tag, input logic [W-1:0] er, input logic [3:0] ee,
                            input int hold);
    int n;
    bit acc;
    bit moved;
    n = 0;
    @(negedge CLK);
    while (!obs_rv && n < 400) begin @(negedge CLK); n++; end
    if (!obs_rv) check({tag, "_valid_timeout"}, 32'(obs_rv), 32'd1);
    check({tag, "_result"}, 32'(obs_res), 32'(er));
    check({tag, "_err"}, 32'(obs_err), 32'(ee));
    if (hold > 0) begin
      acc = 1'b0; moved = 1'b0;
      tok_valid = 1'b1; tok_is_op = 1'b0; tok_data = 8'd99; tok_last = 1'b1;
      repeat (hold) begin
        @(negedge CLK);
        acc   |= obs_rdy;
        moved |= (obs_res !== er) || (obs_err !== ee) || !obs_rv;
      end
      tok_valid = 1'b0; tok_last = 1'b0;
      check({tag, "_no_accept_while_valid"}, 32'(acc), 32'd0);
      check({tag, "_held_stable"}, 32'(moved), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge CLK);
    #1;
    res_ready = 1'b0;
    check({tag, "_valid_dropped"}, 32'(obs_rv), 32'd0);
  endtask

  function automatic int unsigned apply(input int unsigned a, input int unsigned b, input byte op);
    case (op)
      8'd43:   return (a + b) & 32'hFF;
      8'd45:   return (a - b) & 32'hFF;
      8'd42:   return (a * b) & 32'hFF;
      default: begin
        if (b == 0) begin model_dz = 1'b1; return 0; end
        return a / b;
      end
    endcase
  endfunction

  // Two passes: all * and / left to right, then all + and - left to right.
  function automatic int unsigned flat_eval(input int unsigned v[8], input byte o[8], input int n);
    int unsigned sv[8];
    byte         so[8];
    int          m;
    int unsigned cur;
    m = 0; cur = v[0];
    for (int k = 0; k < n - 1; k++) begin
      if (o[k] == 8'd42 || o[k] == 8'd47) cur = apply(cur, v[k+1], o[k]);
      else begin sv[m] = cur; so[m] = o[k]; m++; cur = v[k+1]; end
    end
    sv[m] = cur;
    cur = sv[0];
    for (int k = 0; k < m; k++) cur = apply(cur, sv[k+1], so[k]);
    return cur;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned v[8], iv[8], ov[8];
    byte         o[8], io[8], oo[8];
    byte         opset[4];
    int          n, pi, pj, on, inn;
    bit          paren;
    int unsigned expv;
    string       s;

    opset[0] = 8'd43; opset[1] = 8'd45; opset[2] = 8'd42; opset[3] = 8'd47;
    RST = 1'b1; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = '0; tok_last = 1'b0;
    res_ready = 1'b0; sel = 1'b0; gaps = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_tok_ready", 32'(obs_rdy), 32'd0);
    check("rst_res_valid", 32'(obs_rv), 32'd0);
    check("rst_result", 32'(obs_res), 32'd0);
    check("rst_err", 32'(obs_err), 32'd0);
    check("rst_busy", 32'(obs_busy), 32'd0);
    RST = 1'b0;
    @(posedge CLK);

    // Directed expressions on the DEPTH=11 instance
    send_expr("5 * ( 4 - 2 + 1 ) - 6"); get_result("mixed_paren", 8'd9, 4'd0, 10);
    send_expr("12 / 0 + 3");            get_result("div_zero", 8'd0, 4'd4, 0);
    send_expr("7 * 6");                 get_result("after_err", 8'd42, 4'd0, 0);
    send_expr("( 3 + 4");               get_result("open_paren", 8'd0, 4'd8, 0);
    send_expr("3 + 4 ) * 2 + 1");       get_result("close_paren", 8'd0, 4'd8, 0);
    send_expr("1 + 1");                 get_result("after_drain", 8'd2, 4'd0, 0);
    send_expr("3 x 4");                 get_result("bad_opcode", 8'd0, 4'd8, 0);
    send_expr("77");                    get_result("single_operand", 8'd77, 4'd0, 0);
    send_expr("200 / 7");               get_result("div_trunc", 8'd28, 4'd0, 0);
    send_expr("20 * 20");               get_result("mul_wrap", 8'd144, 4'd0, 0);

    // DEPTH=4 instance
    sel = 1'b1;
    @(posedge CLK);
    send_expr("1+(2+(3+(4+(5+6)))))");  get_result("d4_overflow", 8'd0, 4'd1, 0);
    send_expr("250 + 10");              get_result("d4_add_wrap", 8'd4, 4'd0, 0);
    send_expr("3 - 5");                 get_result("d4_sub_wrap", 8'd254, 4'd0, 0);
    send_expr("5 * ( 4 - 2 + 1 ) - 6"); get_result("d4_mixed", 8'd9, 4'd0, 0);
    sel = 1'b0;
    @(posedge CLK);

    // Reset while reducing: '+' after 2*3 forces a reduction cycle
    send_tok(1'b0, 8'd2, 1'b0);
    send_tok(1'b1, 8'd42, 1'b0);
    send_tok(1'b0, 8'd3, 1'b0);
    send_tok(1'b1, 8'd43, 1'b0);
    check("mid_reduce_busy", 32'(obs_busy), 32'd1);
    check("mid_reduce_not_ready", 32'(obs_rdy), 32'd0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst_tok_ready", 32'(obs_rdy), 32'd0);
    check("midrst_res_valid", 32'(obs_rv), 32'd0);
    check("midrst_result", 32'(obs_res), 32'd0);
    check("midrst_err", 32'(obs_err), 32'd0);
    check("midrst_busy", 32'(obs_busy), 32'd0);
    RST = 1'b0;
    send_expr("2 + 2");                 get_result("post_reset", 8'd4, 4'd0, 0);

    // Random expressions with token gaps and stalled result consumer
    gaps = 1'b1;
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++)
        v[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      for (int k = 0; k < n - 1; k++) o[k] = opset[$urandom_range(0, 3)];
      paren = (n >= 2) && ($urandom_range(0, 1) == 1);
      pi = 0; pj = 0;
      if (paren) begin
        pi = $urandom_range(0, n - 2);
        pj = $urandom_range(pi + 1, n - 1);
      end
      model_dz = 1'b0;
      if (paren) begin
        inn = pj - pi + 1;
        for (int k = 0; k < inn; k++) iv[k] = v[pi + k];
        for (int k = 0; k < inn - 1; k++) io[k] = o[pi + k];
        on = 0;
        for (int k = 0; k < pi; k++) begin ov[on] = v[k]; oo[on] = o[k]; on++; end
        ov[on] = flat_eval(iv, io, inn);
        for (int k = pj; k < n - 1; k++) begin oo[on] = o[k]; on++; ov[on] = v[k + 1]; end
        expv = flat_eval(ov, oo, on + 1);
      end else begin
        expv = flat_eval(v, o, n);
      end
      s = "";
      for (int k = 0; k < n; k++) begin
        if (paren && k == pi) s = {s, "("};
        s = {s, $sformatf("%0d", v[k])};
        if (paren && k == pj) s = {s, ")"};
        if (k < n - 1) s = {s, $sformatf(" %c ", o[k])};
      end
      send_expr(s);
      get_result($sformatf("rand%0d", t), model_dz ? 8'd0 : W'(expv),
                 model_dz ? 4'd4 : 4'd0, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
